debounced_edge_pio: RTL and testbench

Parametrised Avalon-MM input PIO for HPS-facing DIP switches and push-buttons. Replaces the fixed 4-bit, any-edge input PIO with configurable width, input synchroniser depth, per-bit digital debounce, per-bit rising/falling edge selection and a saturating event counter. Sits on the lightweight HPS-to-FPGA bridge and drives one IRQ line into the HPS interrupt controller.

---
 rtl/debounced_edge_pio.sv | 120 ++++++++++++
 tb/tb_debounced_edge_pio.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounced_edge_pio.sv
// Avalon-MM input PIO: synchroniser, per-bit debounce, selectable edge capture,
// masked level IRQ and a saturating capture-event counter.

module debounced_edge_pio_lane #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync,
  output logic stable,
  output logic upd
);
  localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [15:0] cnt;

  assign upd = (sync != stable) && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync == stable) begin
      cnt <= '0;
    end else if (upd) begin
      stable <= sync;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end
endmodule

module debounced_edge_pio #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_out, stable, upd, set;
  logic [WIDTH-1:0] irq_mask, capture, rise_en, fall_en, wd;
  logic [15:0]      evt_cnt;
  logic [31:0]      rd_mux;
  logic             wr, any_set;
  logic             unused_wd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
  end
  assign sync_out = sync_q[SYNC_STAGES-1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    debounced_edge_pio_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .sync   (sync_out[i]),
      .stable (stable[i]),
      .upd    (upd[i])
    );
  end

  // stable still holds the old level during the update cycle, so it tells the edge direction
  assign set       = upd & ((~stable & rise_en) | (stable & fall_en));
  assign any_set   = |set;
  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
      capture  <= '0;
      rise_en  <= '1;
      fall_en  <= '0;
      evt_cnt  <= '0;
    end else begin
      if (wr && address == 3'd2) irq_mask <= wd;
      if (wr && address == 3'd4) rise_en  <= wd;
      if (wr && address == 3'd5) fall_en  <= wd;
      // a new edge overrides a same-cycle W1C of that bit
      capture <= (capture & ~((wr && address == 3'd3) ? wd : '0)) | set;
      if (wr && address == 3'd6)
        evt_cnt <= any_set ? 16'd1 : 16'd0;
      else if (any_set && evt_cnt != 16'hFFFF)
        evt_cnt <= evt_cnt + 16'd1;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0:    rd_mux[WIDTH-1:0] = stable;
      3'd1:    rd_mux[WIDTH-1:0] = sync_out;
      3'd2:    rd_mux[WIDTH-1:0] = irq_mask;
      3'd3:    rd_mux[WIDTH-1:0] = capture;
      3'd4:    rd_mux[WIDTH-1:0] = rise_en;
      3'd5:    rd_mux[WIDTH-1:0] = fall_en;
      3'd6:    rd_mux[15:0]      = evt_cnt;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = |(capture & irq_mask);
endmodule

// File: tb/tb_debounced_edge_pio.sv
// Randomised + directed bench for debounced_edge_pio against a window-based behavioural model;
// a second narrow, fast-debounce instance exercises counter saturation.

module tb_debounced_edge_pio;
  localparam int W  = 4;
  localparam int S  = 2;
  localparam int DC = 16;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata;
  logic [W-1:0] in_port;
  logic [31:0] readdata;
  logic        irq;

  logic        c_reset_n;
  logic [2:0]  c_address;
  logic        c_cs, c_wn;
  logic [31:0] c_wd;
  logic [0:0]  c_in;
  logic [31:0] c_rd;
  logic        c_irq;

  int n_cmp = 0;
  int n_bad = 0;

  debounced_edge_pio #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  debounced_edge_pio #(.WIDTH(1), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut_cnt (
    .clk(clk), .reset_n(c_reset_n), .address(c_address), .chipselect(c_cs),
    .write_n(c_wn), .writedata(c_wd), .in_port(c_in),
    .readdata(c_rd), .irq(c_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Model: the stable level flips once the last DC synchronised samples all disagree with it.
  logic [W-1:0] m_sq[$];
  logic [W-1:0] m_win[$];
  logic [W-1:0] m_stable, m_cap, m_mask, m_rise, m_fall;
  logic [15:0]  m_evt;
  logic [31:0]  m_rd;

  task automatic model_reset();
    m_sq.delete();
    for (int i = 0; i < S; i++) m_sq.push_back('0);
    m_win.delete();
    m_stable = '0; m_cap = '0; m_mask = '0; m_rise = '1; m_fall = '0;
    m_evt = '0; m_rd = '0;
  endtask

  task automatic model_step();
    logic [W-1:0] sy, upd, set;
    logic [31:0]  mux;
    bit           wr, all;
    sy = m_sq[0];
    m_sq.push_back(in_port);
    void'(m_sq.pop_front());
    m_win.push_back(sy);
    if (m_win.size() > DC) void'(m_win.pop_front());
    upd = '0;
    if (m_win.size() == DC)
      for (int b = 0; b < W; b++) begin
        all = 1'b1;
        foreach (m_win[i]) if (m_win[i][b] == m_stable[b]) all = 1'b0;
        upd[b] = all;
      end
    set = (upd & ~m_stable & m_rise) | (upd & m_stable & m_fall);
    case (address)
      3'd0: mux = 32'(m_stable);
      3'd1: mux = 32'(sy);
      3'd2: mux = 32'(m_mask);
      3'd3: mux = 32'(m_cap);
      3'd4: mux = 32'(m_rise);
      3'd5: mux = 32'(m_fall);
      3'd6: mux = 32'(m_evt);
      default: mux = 32'd0;
    endcase
    wr = chipselect && !write_n;
    m_cap = (m_cap & ~((wr && address == 3'd3) ? writedata[W-1:0] : '0)) | set;
    if (wr && address == 3'd2) m_mask = writedata[W-1:0];
    if (wr && address == 3'd4) m_rise = writedata[W-1:0];
    if (wr && address == 3'd5) m_fall = writedata[W-1:0];
    if (wr && address == 3'd6)      m_evt = (set != '0) ? 16'd1 : 16'd0;
    else if (set != '0 && m_evt != 16'hFFFF) m_evt = m_evt + 16'd1;
    m_stable = m_stable ^ upd;
    m_rd = mux;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else          model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("readdata", readdata, m_rd);
      check("irq", 32'(irq), 32'(|(m_cap & m_mask)));
    end
  end

  task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b0; write_n = 1'b1;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic c_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    c_address = a; c_cs = 1'b1; c_wn = 1'b0; c_wd = d;
    @(negedge clk);
    c_cs = 1'b0; c_wn = 1'b1;
  endtask

  task automatic c_rdt(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    c_address = a; c_cs = 1'b0; c_wn = 1'b1;
    @(negedge clk);
    d = c_rd;
  endtask

  task automatic main_seq();
    logic [31:0] d;
    int idx;
    repeat (3) @(negedge clk);
    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    reset_n = 1'b1;
    bus_rd(3'd4, d); check("rise_en_rst", d, 32'hF);

    // clean rise on bit 0, 18-cycle latency
    bus_wr(3'd2, 32'h1);
    @(negedge clk) in_port[0] = 1'b1;
    repeat (17) @(negedge clk);
    check("irq_before_18", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_at_18", 32'(irq), 32'd1);
    bus_rd(3'd0, d); check("rise_data", d, 32'h1);
    bus_rd(3'd3, d); check("rise_cap", d, 32'h1);
    bus_rd(3'd6, d); check("rise_evt", d, 32'd1);
    bus_wr(3'd3, 32'h1);
    check("w1c_irq", 32'(irq), 32'd0);

    // glitch rejection on bit 1
    @(negedge clk) in_port[1] = 1'b1;
    repeat (15) @(negedge clk);
    in_port[1] = 1'b0;
    repeat (25) @(negedge clk);
    bus_rd(3'd0, d); check("glitch_data", d, 32'h1);
    bus_rd(3'd3, d); check("glitch_cap", d, 32'h0);
    bus_rd(3'd6, d); check("glitch_evt", d, 32'd1);
    @(negedge clk) in_port[1] = 1'b1;
    repeat (16) @(negedge clk);
    in_port[1] = 1'b0;
    repeat (25) @(negedge clk);
    bus_rd(3'd3, d); check("pulse16_cap", d, 32'h2);
    bus_rd(3'd6, d); check("pulse16_evt", d, 32'd2);

    // falling-edge only on bit 2
    bus_wr(3'd4, 32'h0);
    bus_wr(3'd5, 32'h4);
    @(negedge clk) in_port[2] = 1'b1;
    repeat (25) @(negedge clk);
    bus_rd(3'd3, d); check("edge_rise_cap", d, 32'h2);
    bus_rd(3'd0, d); check("edge_rise_data", d, 32'h5);
    @(negedge clk) in_port[2] = 1'b0;
    repeat (25) @(negedge clk);
    bus_rd(3'd3, d); check("edge_fall_cap", d, 32'h6);
    bus_rd(3'd0, d); check("edge_fall_data", d, 32'h1);
    bus_rd(3'd6, d); check("edge_fall_evt", d, 32'd3);

    // W1C in the same cycle as a new enabled bit-0 edge
    bus_wr(3'd4, 32'hF);
    bus_wr(3'd5, 32'h0);
    @(negedge clk) in_port[0] = 1'b0;
    repeat (25) @(negedge clk);
    @(negedge clk) in_port[0] = 1'b1;
    repeat (17) @(negedge clk);
    address = 3'd3; chipselect = 1'b1; write_n = 1'b0; writedata = 32'h1;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    bus_rd(3'd3, d); check("race_cap", d, 32'h7);
    bus_rd(3'd6, d); check("race_evt", d, 32'd4);

    // random traffic with one asynchronous reset in the middle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        idx = int'($urandom_range(0, W - 1));
        in_port[idx] = ~in_port[idx];
      end
      address = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        chipselect = 1'($urandom_range(0, 1));
        write_n    = 1'($urandom_range(0, 1));
        writedata  = $urandom;
      end
      if (c == 1500) begin
        #2 reset_n = 1'b0;
        @(negedge clk);
        check("midrst_readdata", readdata, 32'd0);
        check("midrst_irq", 32'(irq), 32'd0);
        #2 reset_n = 1'b1;
      end
    end
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic cnt_seq();
    logic [31:0] d;
    repeat (3) @(negedge clk);
    c_reset_n = 1'b1;
    c_wr(3'd5, 32'h1);
    // every toggle becomes one capture event with DEBOUNCE_CYCLES=1
    for (int i = 0; i < 65540; i++) begin
      @(negedge clk);
      c_in = ~c_in;
    end
    repeat (5) @(negedge clk);
    c_rdt(3'd6, d); check("evt_saturated", d, 32'hFFFF);
    c_rdt(3'd0, d); check("cnt_data", d, 32'h0);
    @(negedge clk) c_in = 1'b1;
    repeat (2) @(negedge clk);
    c_address = 3'd6; c_cs = 1'b1; c_wn = 1'b0; c_wd = 32'h0;
    @(negedge clk);
    c_cs = 1'b0; c_wn = 1'b1;
    c_rdt(3'd6, d); check("evt_clear_and_inc", d, 32'd1);
    @(negedge clk) c_in = 1'b0;
    repeat (5) @(negedge clk);
    c_rdt(3'd6, d); check("evt_after_clear", d, 32'd2);
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    c_reset_n = 1'b0; c_address = '0; c_cs = 1'b0; c_wn = 1'b1;
    c_wd = '0; c_in = '0;
    fork
      main_seq();
      cnt_seq();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
